// File: rtl/msdap_pkg.sv
// Shared types and constants for the MSDAP output capture block.
package msdap_pkg;

  localparam int unsigned MSDAP_OUT_W = 40;

  typedef enum logic [0:0] {
    CAP_IDLE  = 1'b0,
    CAP_SHIFT = 1'b1
  } cap_state_t;

  // Bit width needed to index or count up to v-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/outcap_fifo.sv
// Register-based FIFO for captured {L,R} word pairs; simultaneous push/pop is legal when full.
module outcap_fifo
  import msdap_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * MSDAP_OUT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int unsigned AW = clog2_min1(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             do_push, do_pop;

  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it.
  always_comb begin
    do_pop   = pop && valid_q;
    do_push  = push && (!full_q || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    valid_d = (cnt_d != CW'(0));
    full_d  = (cnt_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  assign dout  = valid_q ? mem_q[rd_ptr_q] : '0;
  assign valid = valid_q;
  assign full  = full_q;

endmodule

// File: rtl/msdap_out_capture.sv
// Deserialises the MSDAP L/R serial outputs into word pairs and queues them for a consumer.
// Optional OUTCAP_WORDCNT_EN adds a 16-bit count of accepted words on port word_cnt.
module msdap_out_capture
  import msdap_pkg::*;
#(
  parameter int unsigned WORD_W = MSDAP_OUT_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              SCLK,
  input  logic              Reset,
  input  logic              OutReady,
  input  logic              OutputL,
  input  logic              OutputR,
  input  logic              rd_en,
  input  logic              clr_flags,
  output logic              valid,
  output logic [WORD_W-1:0] DataL,
  output logic [WORD_W-1:0] DataR,
  output logic              full,
  output logic              frame_err,
`ifdef OUTCAP_WORDCNT_EN
  output logic [15:0]       word_cnt,
`endif
  output logic              overflow
);

  localparam int unsigned CNT_W = clog2_min1(WORD_W + 1);

  cap_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WORD_W-1:0]   shl_q, shl_d;
  logic [WORD_W-1:0]   shr_q, shr_d;
  logic                frame_err_q, frame_err_d;
  logic                overflow_q, overflow_d;
  logic                push_req, frame_set, overflow_set;
  logic [2*WORD_W-1:0] fifo_dout;

  // Capture FSM: the first bit of a word is taken in IDLE, the word completes on the WORD_W-th bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shl_d     = shl_q;
    shr_d     = shr_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    cnt_inc   = cnt_q + CNT_W'(1);
    case (state_q)
      CAP_IDLE: begin
        if (OutReady) begin
          shl_d   = {shl_q[WORD_W-2:0], OutputL};
          shr_d   = {shr_q[WORD_W-2:0], OutputR};
          cnt_d   = cnt_inc;
          state_d = CAP_SHIFT;
        end
      end
      CAP_SHIFT: begin
        if (OutReady) begin
          shl_d = {shl_q[WORD_W-2:0], OutputL};
          shr_d = {shr_q[WORD_W-2:0], OutputR};
          cnt_d = cnt_inc;
        end else begin
          frame_set = 1'b1;
          cnt_d     = '0;
          state_d   = CAP_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = CAP_IDLE;
      end
    endcase
    if (OutReady && (cnt_inc == CNT_W'(WORD_W))) begin
      push_req = 1'b1;
      cnt_d    = '0;
      state_d  = CAP_IDLE;
    end
  end

  // Setting events take priority over a same-cycle clear.
  always_comb begin
    overflow_set = push_req && full && !rd_en;
    frame_err_d  = frame_set || (frame_err_q && !clr_flags);
    overflow_d   = overflow_set || (overflow_q && !clr_flags);
  end

  always_ff @(posedge SCLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= CAP_IDLE;
      cnt_q       <= '0;
      shl_q       <= '0;
      shr_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  outcap_fifo #(
    .WIDTH (2 * WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (SCLK),
    .rst   (Reset),
    .push  (push_req),
    .pop   (rd_en),
    .din   ({shl_d, shr_d}),
    .dout  (fifo_dout),
    .valid (valid),
    .full  (full)
  );

`ifdef OUTCAP_WORDCNT_EN
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        accept;

  // Counts only pairs the FIFO actually took; wraps naturally at 16 bits.
  always_comb begin
    accept     = push_req && (!full || rd_en);
    word_cnt_d = accept ? (word_cnt_q + 16'(1)) : word_cnt_q;
  end

  always_ff @(posedge SCLK or posedge Reset) begin
    if (Reset) begin
      word_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
    end
  end

  assign word_cnt = word_cnt_q;
`endif

  assign DataL     = fifo_dout[2*WORD_W-1:WORD_W];
  assign DataR     = fifo_dout[WORD_W-1:0];
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_msdap_out_capture.sv
// Scoreboard bench for msdap_out_capture: a word-level reference model queues expected pairs,
// a negedge monitor compares the DUT head, status and flags against it every cycle.
module tb_msdap_out_capture;
  import msdap_pkg::*;

  localparam int unsigned W = 40;
  localparam int unsigned D = 4;

  logic SCLK = 1'b0;
  logic Reset = 1'b1;
  logic OutReady = 1'b0;
  logic OutputL = 1'b0;
  logic OutputR = 1'b0;
  logic rd_en = 1'b0;
  logic clr_flags = 1'b0;
  logic valid, full, frame_err, overflow;
  logic [W-1:0] DataL, DataR;
`ifdef OUTCAP_WORDCNT_EN
  logic [15:0] word_cnt;
`endif

  msdap_out_capture #(.WORD_W(W), .DEPTH(D)) dut (
    .SCLK      (SCLK),
    .Reset     (Reset),
    .OutReady  (OutReady),
    .OutputL   (OutputL),
    .OutputR   (OutputR),
    .rd_en     (rd_en),
    .clr_flags (clr_flags),
    .valid     (valid),
    .DataL     (DataL),
    .DataR     (DataR),
    .full      (full),
    .frame_err (frame_err),
`ifdef OUTCAP_WORDCNT_EN
    .word_cnt  (word_cnt),
`endif
    .overflow  (overflow)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
  } pair_t;

  pair_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  bit    mon_en = 1'b0;

  // Reference model state: bits received of the word in flight and the words they form.
  int           m_bits = 0;
  logic [W-1:0] m_l = '0;
  logic [W-1:0] m_r = '0;
  bit           m_fe = 1'b0;
  bit           m_ov = 1'b0;
  int           m_wc = 0;
  int           m_occ;
  bit           m_done, m_fe_set, m_ov_set, m_pop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge SCLK or posedge Reset) begin
    if (Reset) begin
      exp_q.delete();
      m_bits = 0;
      m_fe   = 1'b0;
      m_ov   = 1'b0;
      m_wc   = 0;
    end else begin
      m_occ    = exp_q.size();
      m_pop    = rd_en && (m_occ > 0);
      m_done   = 1'b0;
      m_fe_set = 1'b0;
      m_ov_set = 1'b0;
      if (OutReady) begin
        m_l    = (m_l << 1) | W'(OutputL);
        m_r    = (m_r << 1) | W'(OutputR);
        m_bits = m_bits + 1;
        if (m_bits == W) begin
          m_done = 1'b1;
          m_bits = 0;
        end
      end else if (m_bits > 0) begin
        m_fe_set = 1'b1;
        m_bits   = 0;
      end
      if (m_pop) void'(exp_q.pop_front());
      if (m_done) begin
        if (m_occ < D || m_pop) begin
          exp_q.push_back('{l: m_l, r: m_r});
          m_wc = (m_wc + 1) % 65536;
        end else begin
          m_ov_set = 1'b1;
        end
      end
      m_fe = m_fe_set || (m_fe && !clr_flags);
      m_ov = m_ov_set || (m_ov && !clr_flags);
    end
  end

  // Monitor: outputs only move on posedge or async reset, so negedge sampling is stable.
  always @(negedge SCLK) begin
    if (mon_en) begin
      chk("valid", 64'(valid), 64'(exp_q.size() != 0));
      chk("full", 64'(full), 64'(exp_q.size() == D));
      chk("frame_err", 64'(frame_err), 64'(m_fe));
      chk("overflow", 64'(overflow), 64'(m_ov));
      if (exp_q.size() != 0) begin
        chk("DataL", 64'(DataL), 64'(exp_q[0].l));
        chk("DataR", 64'(DataR), 64'(exp_q[0].r));
      end
`ifdef OUTCAP_WORDCNT_EN
      chk("word_cnt", 64'(word_cnt), 64'(m_wc));
`endif
    end
  end

  task automatic send_bits(input logic [W-1:0] l, input logic [W-1:0] r,
                           input int nbits, input bit rd_last);
    for (int i = 0; i < nbits; i++) begin
      OutReady = 1'b1;
      OutputL  = l[W-1-i];
      OutputR  = r[W-1-i];
      rd_en    = rd_last && (i == nbits - 1);
      @(negedge SCLK);
    end
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    OutReady = 1'b0;
    OutputL  = 1'b0;
    OutputR  = 1'b0;
    rd_en    = 1'b0;
    repeat (n) @(negedge SCLK);
  endtask

  task automatic clr_pulse();
    clr_flags = 1'b1;
    @(negedge SCLK);
    clr_flags = 1'b0;
  endtask

  task automatic drain();
    OutReady = 1'b0;
    for (int k = 0; k < D + 2 && exp_q.size() > 0; k++) begin
      rd_en = 1'b1;
      @(negedge SCLK);
    end
    rd_en = 1'b0;
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {8'($urandom), 32'($urandom)};
  endfunction

  logic [W-1:0] wl [5];
  logic [W-1:0] wr [5];

  initial begin
    repeat (3) @(negedge SCLK);
    mon_en = 1'b1;
    @(negedge SCLK);
    Reset = 1'b0;
    idle(2);

    // Single known word, then rd_en while empty is harmless.
    send_bits(40'h80_0000_0001, 40'h00_FFFF_FF00, W, 1'b0);
    idle(3);
    drain();
    rd_en = 1'b1;
    idle(1);
    rd_en = 1'b1;
    @(negedge SCLK);
    rd_en = 1'b0;

    // Three back-to-back words.
    for (int i = 0; i < 3; i++) begin
      wl[i] = rnd_word();
      wr[i] = rnd_word();
      send_bits(wl[i], wr[i], W, 1'b0);
    end
    idle(2);
    drain();

    // Short frame, then a clean word, then clear.
    send_bits(rnd_word(), rnd_word(), 25, 1'b0);
    idle(2);
    send_bits(rnd_word(), rnd_word(), W, 1'b0);
    idle(2);
    clr_pulse();
    idle(1);
    drain();

    // Five words into a four-deep FIFO.
    for (int i = 0; i < 5; i++) begin
      wl[i] = rnd_word();
      wr[i] = rnd_word();
      send_bits(wl[i], wr[i], W, 1'b0);
    end
    idle(2);
    clr_pulse();
    idle(1);

    // Push and pop together while full.
    send_bits(rnd_word(), rnd_word(), W, 1'b1);
    idle(2);
    drain();

    // Leave state behind, then reset at bit 17 of a word.
    send_bits(rnd_word(), rnd_word(), 10, 1'b0);
    idle(1);
    send_bits(rnd_word(), rnd_word(), W, 1'b0);
    send_bits(rnd_word(), rnd_word(), 17, 1'b0);
    #2;
    Reset    = 1'b1;
    OutReady = 1'b0;
    #1;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_DataL", 64'(DataL), 64'(0));
    chk("rst_DataR", 64'(DataR), 64'(0));
    chk("rst_frame_err", 64'(frame_err), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
`ifdef OUTCAP_WORDCNT_EN
    chk("rst_word_cnt", 64'(word_cnt), 64'(0));
`endif
    @(negedge SCLK);
    @(negedge SCLK);
    Reset = 1'b0;
    idle(2);
    send_bits(rnd_word(), rnd_word(), W, 1'b0);
    idle(2);
    drain();

    // Random traffic: rare frame drops, slow then fast consumer, occasional flag clears.
    for (int c = 0; c < 1200; c++) begin
      OutReady  = ($urandom_range(0, 99) != 0);
      OutputL   = 1'($urandom);
      OutputR   = 1'($urandom);
      rd_en     = (c < 600) ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 3) == 0);
      clr_flags = ($urandom_range(0, 49) == 0);
      @(negedge SCLK);
    end
    clr_flags = 1'b0;
    idle(2);
    drain();
    idle(1);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msdap_out_capture.md
MSDAP_OUT_CAPTURE -- requirements
Module: msdap_out_capture

Interface
REQ-001 The block SHALL have parameter WORD_W, default 40, meaning the serial word length in bits per channel.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, 2..16).
REQ-003 Clock and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-high.
REQ-004 SCLK  in  1  system clock; every register samples on its rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 OutReady  in  1  high while one serial output bit per SCLK cycle is presented.
REQ-007 OutputL  in  1  left-channel serial data, MSB first.
REQ-008 OutputR  in  1  right-channel serial data, MSB first.
REQ-009 rd_en  in  1  consumer pops the head entry when this is high and valid is high.
REQ-010 clr_flags  in  1  synchronous clear of the sticky error flags.
REQ-011 valid  out  1  FIFO not empty; the head entry is on DataL/DataR.
REQ-012 DataL  out  WORD_W  left-channel word at the FIFO head.
REQ-013 DataR  out  WORD_W  right-channel word at the FIFO head.
REQ-014 full  out  1  FIFO holds DEPTH entries.
REQ-015 frame_err  out  1  sticky flag: OutReady fell before WORD_W bits were received.
REQ-016 overflow  out  1  sticky flag: a completed word was dropped because the FIFO was full.

Function
REQ-017 The capture FSM SHALL have two states, IDLE and SHIFT.
REQ-018 In IDLE, OutReady=1 SHALL shift in bit WORD_W-1, set bit count = 1, and move the FSM to SHIFT.
REQ-019 In SHIFT, each cycle with OutReady=1 SHALL shift OutputL and OutputR left into 40-bit shift registers and increment the bit count.
REQ-020 When the bit count reaches WORD_W, the completed {L,R} pair SHALL be pushed on that same edge; the pair is visible on DataL/DataR one cycle after the last bit when the FIFO was empty.
REQ-021 After a push, the bit count SHALL return to 0 and the FSM SHALL return to IDLE.
REQ-022 If OutReady is still 1 in the cycle after a push, that bit SHALL start the next word (back-to-back frames, no gap required).
REQ-023 If OutReady=0 in SHIFT with bit count < WORD_W, the block SHALL discard the partial word, set frame_err, and return to IDLE.
REQ-024 On a pop, when rd_en=1 and valid=1, the head SHALL advance on the edge; rd_en while valid=0 SHALL be ignored.
REQ-025 A push and a pop in the same cycle SHALL both occur, the occupancy SHALL stay unchanged, and this SHALL be legal when full.
REQ-026 A push while full without a simultaneous pop SHALL drop the new pair, set overflow, and leave the FIFO contents intact.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH, and the occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-028 clr_flags=1 SHALL clear frame_err and overflow on the next edge; a flag-setting event in the same cycle SHALL win, so the flag ends set.

Reset
REQ-029 Reset SHALL asynchronously force: FSM=IDLE, bit count=0, pointers and occupancy=0, valid=0, full=0, frame_err=0, overflow=0, DataL=DataR=0.
REQ-030 Reset asserted mid-word SHALL discard the partial word; after release, capture SHALL begin only at the next OutReady=1 seen in IDLE.

Configuration
REQ-031 With macro OUTCAP_WORDCNT_EN defined, the block SHALL add output word_cnt [15:0], a count of accepted pushes that wraps at 65535->0, resets to 0, and does not count dropped words.
REQ-032 Without OUTCAP_WORDCNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 Package msdap_pkg SHALL hold the FSM state enum (cap_state_t: CAP_IDLE, CAP_SHIFT) and the constant MSDAP_OUT_W = 40.
REQ-034 The FIFO SHALL be a separate sub-module named outcap_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, valid, full); the FSM and shift registers stay in the top module.

Verification
REQ-035 Single word: OutReady high 40 cycles; L = 0x80_0000_0001, R = 0x00_FFFF_FF00 serial -> valid rises 1 cycle after the last bit; DataL/DataR match.
REQ-036 Back-to-back: 3 words in 120 continuous OutReady cycles with rd_en=0 -> 3 entries in order, full=0, frame_err=0.
REQ-037 Short frame: OutReady high 25 cycles, then low -> frame_err=1, valid=0; the next full 40-bit word is captured correctly.
REQ-038 Overflow: 5 words with DEPTH=4 and rd_en=0 -> full=1, overflow=1, and entries 0-3 equal words 1-4; with clr_flags pulsed, overflow=0.
REQ-039 Simultaneous push/pop while full: rd_en=1 on the 40th bit of a word -> occupancy stays 4, overflow=0, head advances.
REQ-040 Reset at bit 17 of a word -> all outputs 0 immediately; a following clean word is captured; word_cnt=1 when OUTCAP_WORDCNT_EN is defined.
